pd_match_logger: RTL and testbench

Downstream consumer of the pattern-detect stage. Samples the detector's product word and match flag every enabled cycle, time-stamps each match, and buffers matches in a small FIFO drained by a valid/ready stream. Keeps saturating match and drop counters plus a sticky overflow flag, so software or a debug port can read match events without back-pressuring the arithmetic path.

---
 rtl/pd_log_pkg.sv | 14 +
 rtl/pd_log_fifo.sv | 63 ++++++
 rtl/pd_match_logger.sv | 101 ++++++++++
 tb/tb_pd_match_logger.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pd_log_pkg.sv
// Shared defaults and constants for the pattern-detect match logger.
package pd_log_pkg;

  localparam int DATA_W_DEF = 21;
  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 16;

  // One FIFO entry is {timestamp, product word}.
  localparam int ENTRY_W = TS_W_DEF + DATA_W_DEF;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pd_log_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module pd_log_fifo
  import pd_log_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which words are meaningful, and the head is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign valid = ~empty;
  assign level = level_q;

endmodule

// File: rtl/pd_match_logger.sv
// Time-stamps detector matches into a FIFO with saturating counters.
// Define PD_LOG_EDGE_EN to log only the rising edge of a match run.
module pd_match_logger
  import pd_log_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [DATA_W-1:0]      c_i,
  input  logic                   ones_i,
  input  logic                   clr_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_W-1:0]      m_data_o,
  output logic [TS_W-1:0]        m_ts_o,
  output logic [CNT_W-1:0]       match_cnt_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic [TS_W-1:0]        ts_q;
  logic                   evt;
  logic                   pop;
  logic                   full;
  logic                   accept;
  logic                   drop;
  logic [TS_W+DATA_W-1:0] head;
  logic [CNT_W-1:0]       match_q;
  logic [CNT_W-1:0]       drop_q;
  logic                   ovf_q;

`ifdef PD_LOG_EDGE_EN
  logic prev_q;

  // Previous qualified match; an idle (en_i low) cycle breaks the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= en_i & ones_i;
  end

  assign evt = en_i & ones_i & ~prev_q;
`else
  assign evt = en_i & ones_i;
`endif

  assign pop    = m_valid_o & m_ready_i;
  assign accept = evt & (~full | pop);
  assign drop   = evt & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // Clear wins over a coincident event; the entry itself is still pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      match_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (evt && match_q != SAT) match_q <= match_q + 1'b1;
      if (drop && drop_q != SAT) drop_q  <= drop_q + 1'b1;
      if (drop)                  ovf_q   <= 1'b1;
    end
  end

  pd_log_fifo #(
    .WIDTH (TS_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   ({ts_q, c_i}),
    .pop   (pop),
    .dout  (head),
    .valid (m_valid_o),
    .full  (full),
    .level (level_o)
  );

  assign m_ts_o      = head[TS_W+DATA_W-1:DATA_W];
  assign m_data_o    = head[DATA_W-1:0];
  assign match_cnt_o = match_q;
  assign drop_cnt_o  = drop_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pd_match_logger.sv
// Scoreboard bench for pd_match_logger; honours PD_LOG_EDGE_EN when defined.
module tb_pd_match_logger;

  localparam int DATA_W = 21;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
`ifdef PD_LOG_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en_i, ones_i, clr_i, m_ready_i;
  logic [DATA_W-1:0] c_i;
  logic              m_valid_o, overflow_o;
  logic [DATA_W-1:0] m_data_o;
  logic [TS_W-1:0]   m_ts_o;
  logic [CNT_W-1:0]  match_cnt_o, drop_cnt_o;
  logic [3:0]        level_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TS_W-1:0]        cyc;
  logic [TS_W+DATA_W-1:0] exp_q[$];
  int                     m_level;
  int                     m_match, m_drop;
  bit                     m_ovf, m_prev;

  pd_match_logger #(
    .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .c_i(c_i), .ones_i(ones_i),
    .clr_i(clr_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_ts_o(m_ts_o), .match_cnt_o(match_cnt_o),
    .drop_cnt_o(drop_cnt_o), .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: equals the timestamp in the cycle being sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an entry presented with ready high leaves at the next edge.
  always @(negedge clk) begin
    logic [TS_W+DATA_W-1:0] e;
    if (rst_n && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", 64'(m_ts_o), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("head_ts", 64'(m_ts_o), 64'(e[TS_W+DATA_W-1:DATA_W]));
        check("head_data", 64'(m_data_o), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_level = 0; m_match = 0; m_drop = 0; m_ovf = 1'b0; m_prev = 1'b0;
  endtask

  // Drive one cycle, predict its effect, then check registered state after the edge.
  task automatic step(input logic en, input logic ones, input logic [DATA_W-1:0] c,
                      input logic rdy, input logic clr);
    bit pp, ev, acc;
    en_i = en; ones_i = ones; c_i = c; m_ready_i = rdy; clr_i = clr;
    pp  = rdy && (m_level > 0);
    ev  = en && ones && !(EDGE && m_prev);
    acc = ev && ((m_level < DEPTH) || pp);
    if (acc) exp_q.push_back({cyc, c});
    m_level = m_level + int'(acc) - int'(pp);
    m_prev  = en && ones;
    if (clr) begin
      m_match = 0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      if (ev && m_match != 16'hFFFF) m_match++;
      if (ev && !acc) begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("level", 64'(level_o), 64'(m_level));
    check("valid", 64'(m_valid_o), 64'(m_level > 0));
    check("match_cnt", 64'(match_cnt_o), 64'(m_match));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(m_valid_o), 64'd0);
    check({tag, "_data"}, 64'(m_data_o), 64'd0);
    check({tag, "_ts"}, 64'(m_ts_o), 64'd0);
    check({tag, "_level"}, 64'(level_o), 64'd0);
    check({tag, "_match"}, 64'(match_cnt_o), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; ones_i = 1'b0; clr_i = 1'b0;
    m_ready_i = 1'b0; c_i = '0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Single match (12 * 2 = 24) at timestamp 5, consumer ready.
    while (cyc != 16'd5) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 21'd24, 1'b1, 1'b0);
    check("single_match_cnt", 64'(match_cnt_o), 64'd1);
    check("single_valid_on", 64'(m_valid_o), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("single_valid_off", 64'(m_valid_o), 64'd0);

    // Ten back-to-back matches with the consumer stalled.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 21'(100 + i), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    // Match coinciding with a pop while full.
    step(1'b1, 1'b1, 21'd500, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Clear with three entries queued and a match in the same cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 21'(200 + i), 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 21'd300, 1'b0, 1'b1);
    check("clr_match", 64'(match_cnt_o), 64'd0);
    check("clr_drop", 64'(drop_cnt_o), 64'd0);
    check("clr_ovf", 64'(overflow_o), 64'd0);
    check("clr_level", 64'(level_o), 64'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Match run: high 4, low 1, high 2.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 21'(400 + i), 1'b1, 1'b0);
    step(1'b1, 1'b0, 21'd404, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 21'(405 + i), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // en_i low makes inputs ignored.
    step(1'b0, 1'b1, 21'd777, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a burst with five entries queued.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 21'(600 + i), 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    check("pre_reset_level", 64'(level_o), 64'd5);
    en_i = 1'b1; ones_i = 1'b1; c_i = 21'd650;
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    model_reset();
    en_i = 1'b0; ones_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    // First sampled match after release carries timestamp 0.
    step(1'b1, 1'b1, 21'd42, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
